// File: rtl/lampfpu_f2i_round.sv
// Float-to-integer rounding back end: applies the rounding mode to a guard/sticky
// extended magnitude, then negates and saturates into a signed or unsigned integer.
module lampfpu_f2i_round #(
   parameter int LAMP_INTEGER_DW = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic                       s_i,
   input  logic [LAMP_INTEGER_DW+2:0] f_i,
   input  logic                       isOverflow_i,
   input  logic                       isSNaN_i,
   input  logic                       isQNaN_i,
   input  logic [2:0]                 rndMode_i,
   input  logic                       isSigned_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [LAMP_INTEGER_DW-1:0] int_o,
   output logic                       isInvalid_o,
   output logic                       isInexact_o
);

   localparam int DW = LAMP_INTEGER_DW;

   localparam logic [2:0] RND_RNE = 3'b000;
   localparam logic [2:0] RND_RTZ = 3'b001;
   localparam logic [2:0] RND_RDN = 3'b010;
   localparam logic [2:0] RND_RUP = 3'b011;
   localparam logic [2:0] RND_RMM = 3'b100;

   localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] ALL_ONE = {DW{1'b1}};

   typedef struct packed {
      logic          sign;
      logic [DW:0]   mag;       // rounded magnitude, MSB is the rounding carry-out
      logic          inexact;
      logic          nan;
      logic          ovf;
      logic          is_signed;
   } s1_t;

   // ---------------------------------------------------------------- handshake
   logic s1_vld_q, s1_vld_d;
   logic s2_vld_q, s2_vld_d;
   logic s2_adv, s1_adv, in_fire;

   assign s2_adv  = !s2_vld_q || ready_i;
   assign s1_adv  = s1_vld_q && s2_adv;
   assign ready_o = !s1_vld_q || s1_adv;
   assign in_fire = valid_i && ready_o;

   always_comb begin
      s1_vld_d = s1_vld_q;
      if (in_fire)
         s1_vld_d = 1'b1;
      else if (s1_adv)
         s1_vld_d = 1'b0;
   end

   always_comb begin
      s2_vld_d = s2_vld_q;
      if (s2_adv)
         s2_vld_d = s1_vld_q;
   end

   // ---------------------------------------------------------------- stage 1: round
   logic g_bit, st_bit, l_bit, rnd_up;
   s1_t  s1_q, s1_d;

   assign g_bit  = f_i[2];
   assign st_bit = |f_i[1:0];
   assign l_bit  = f_i[3];

   always_comb begin
      rnd_up = 1'b0;
      case (rndMode_i)
         RND_RTZ: rnd_up = 1'b0;
         RND_RDN: rnd_up = s_i & (g_bit | st_bit);
         RND_RUP: rnd_up = ~s_i & (g_bit | st_bit);
         RND_RMM: rnd_up = g_bit;
         RND_RNE: rnd_up = g_bit & (st_bit | l_bit);
         default: rnd_up = g_bit & (st_bit | l_bit);
      endcase
   end

   always_comb begin
      s1_d           = s1_q;
      if (in_fire) begin
         s1_d.sign      = s_i;
         s1_d.mag       = {1'b0, f_i[DW+2:3]} + {{DW{1'b0}}, rnd_up};
         s1_d.inexact   = g_bit | st_bit;
         s1_d.nan       = isSNaN_i | isQNaN_i;
         s1_d.ovf       = isOverflow_i;
         s1_d.is_signed = isSigned_i;
      end
   end

   // ---------------------------------------------------------------- stage 2: negate + saturate
   logic          pos_ovf, neg_ovf, mag_nz;
   logic [DW-1:0] res_c;
   logic          inv_c, inx_c;
   logic [DW-1:0] int_q, int_d;
   logic          inv_q, inv_d, inx_q, inx_d;

   // Signed range is asymmetric: a negative result may reach 2^(DW-1).
   assign pos_ovf = |s1_q.mag[DW:DW-1];
   assign neg_ovf = s1_q.mag[DW] | (s1_q.mag[DW-1] & (|s1_q.mag[DW-2:0]));
   assign mag_nz  = |s1_q.mag;

   always_comb begin
      res_c = s1_q.mag[DW-1:0];
      inv_c = 1'b0;
      if (s1_q.nan) begin
         res_c = s1_q.is_signed ? MAX_POS : ALL_ONE;
         inv_c = 1'b1;
      end else if (s1_q.is_signed) begin
         if (s1_q.sign) begin
            if (s1_q.ovf || neg_ovf) begin
               res_c = MIN_NEG;
               inv_c = 1'b1;
            end else begin
               res_c = -s1_q.mag[DW-1:0];
            end
         end else if (s1_q.ovf || pos_ovf) begin
            res_c = MAX_POS;
            inv_c = 1'b1;
         end
      end else begin
         if (s1_q.sign) begin
            // Negatives clamp to zero; only a nonzero magnitude is an error.
            res_c = '0;
            inv_c = s1_q.ovf | mag_nz;
         end else if (s1_q.ovf || s1_q.mag[DW]) begin
            res_c = ALL_ONE;
            inv_c = 1'b1;
         end
      end
      inx_c = s1_q.inexact & ~inv_c;
   end

   always_comb begin
      int_d = int_q;
      inv_d = inv_q;
      inx_d = inx_q;
      if (s1_adv) begin
         int_d = res_c;
         inv_d = inv_c;
         inx_d = inx_c;
      end
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s1_q     <= '0;
         int_q    <= '0;
         inv_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s1_q     <= s1_d;
         int_q    <= int_d;
         inv_q    <= inv_d;
         inx_q    <= inx_d;
      end
   end

   assign valid_o     = s2_vld_q;
   assign int_o       = int_q;
   assign isInvalid_o = inv_q;
   assign isInexact_o = inx_q;

endmodule

// File: tb/tb_lampfpu_f2i_round.sv
// Directed + random bench for lampfpu_f2i_round with an in-order expectation queue.
module tb_lampfpu_f2i_round;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic          s_i = 1'b0;
   logic [DW+2:0] f_i = '0;
   logic          isOverflow_i = 1'b0;
   logic          isSNaN_i = 1'b0;
   logic          isQNaN_i = 1'b0;
   logic [2:0]    rndMode_i = 3'b000;
   logic          isSigned_i = 1'b1;
   logic          valid_o;
   logic          ready_i = 1'b1;
   logic [DW-1:0] int_o;
   logic          isInvalid_o;
   logic          isInexact_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW+1:0] exp_q[$];
   logic          hold_v = 1'b0;
   logic [DW+1:0] hold_val = '0;
   logic [DW+1:0] exp_v;
   bit            rand_rdy = 1'b0;

   lampfpu_f2i_round #(.LAMP_INTEGER_DW(DW)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .s_i(s_i), .f_i(f_i),
      .isOverflow_i(isOverflow_i), .isSNaN_i(isSNaN_i), .isQNaN_i(isQNaN_i),
      .rndMode_i(rndMode_i), .isSigned_i(isSigned_i), .valid_o(valid_o), .ready_i(ready_i),
      .int_o(int_o), .isInvalid_o(isInvalid_o), .isInexact_o(isInexact_o)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, {result, invalid, inexact}
   function automatic logic [DW+1:0] model(input bit s, input logic [DW+2:0] f, input bit ov,
                                           input bit sn, input bit qn, input logic [2:0] m,
                                           input bit sg);
      longint unsigned mag, r;
      bit g, st, l, up, inv;
      logic [DW-1:0] res;
      mag = 64'(f >> 3);
      g = f[2]; st = |f[1:0]; l = f[3];
      case (m)
         3'd1:    up = 1'b0;
         3'd2:    up = s && (g || st);
         3'd3:    up = !s && (g || st);
         3'd4:    up = g;
         default: up = g && (st || l);
      endcase
      r = mag + 64'(up);
      inv = 1'b0;
      if (sn || qn) begin
         res = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF; inv = 1'b1;
      end else if (sg) begin
         if (!s && (ov || r > 64'h7FFF_FFFF)) begin res = 32'h7FFF_FFFF; inv = 1'b1; end
         else if (s && (ov || r > 64'h8000_0000)) begin res = 32'h8000_0000; inv = 1'b1; end
         else res = s ? 32'(-longint'(r)) : 32'(r);
      end else begin
         if (ov) begin res = s ? 32'h0 : 32'hFFFF_FFFF; inv = 1'b1; end
         else if (s) begin res = 32'h0; inv = (r != 0); end
         else if (r > 64'hFFFF_FFFF) begin res = 32'hFFFF_FFFF; inv = 1'b1; end
         else res = 32'(r);
      end
      return {res, inv, (g || st) && !inv};
   endfunction

   // Output monitor: pops expectations on each transfer, checks stability while stalled.
   always @(negedge clk) begin
      if (rst) begin
         if (hold_v) begin
            n_tests++;
            assert (valid_o === 1'b1 && {int_o, isInvalid_o, isInexact_o} === hold_val) else begin
               n_fail++;
               $error("FAIL stall_hold obs v=%b %h exp v=1 %h", valid_o,
                      {int_o, isInvalid_o, isInexact_o}, hold_val);
            end
         end
         if (valid_o && ready_i) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_out obs=%h exp=none", int_o);
            end
            if (exp_q.size() != 0) begin
               exp_v = exp_q.pop_front();
               n_tests++;
               assert ({int_o, isInvalid_o, isInexact_o} === exp_v) else begin
                  n_fail++;
                  $error("FAIL result obs int=%h inv=%b inx=%b exp int=%h inv=%b inx=%b",
                         int_o, isInvalid_o, isInexact_o, exp_v[DW+1:2], exp_v[1], exp_v[0]);
               end
            end
         end
      end
      hold_v   = rst && valid_o && !ready_i;
      hold_val = {int_o, isInvalid_o, isInexact_o};
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Entered and left just after a rising edge; the transfer happens on the edge in between.
   task automatic send(input bit s, input logic [DW+2:0] f, input bit ov, input bit sn,
                       input bit qn, input logic [2:0] m, input bit sg);
      bit done;
      done = 1'b0;
      s_i = s; f_i = f; isOverflow_i = ov; isSNaN_i = sn; isQNaN_i = qn;
      rndMode_i = m; isSigned_i = sg; valid_i = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (ready_o) begin
            exp_q.push_back(model(s, f, ov, sn, qn, m, sg));
            done = 1'b1;
         end
         step();
         if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      end
      valid_i = 1'b0;
      n_tests++;
      assert (done) else begin
         n_fail++;
         $error("FAIL send_timeout obs=not_accepted exp=accepted");
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         step();
         k++;
      end
      n_tests++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL drain_timeout obs=%0d pending exp=0", exp_q.size());
      end
   endtask

   initial begin
      logic [DW+2:0] rf;
      // reset state
      repeat (3) step();
      @(negedge clk);
      n_tests++;
      assert ({valid_o, int_o, isInvalid_o, isInexact_o} === '0) else begin
         n_fail++;
         $error("FAIL reset_state obs v=%b int=%h inv=%b inx=%b exp all 0",
                valid_o, int_o, isInvalid_o, isInexact_o);
      end
      step();
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      assert (ready_o === 1'b1) else begin
         n_fail++;
         $error("FAIL ready_after_reset obs=%b exp=1", ready_o);
      end
      step();

      // 2.5 RNE signed -> 2, with 2-cycle latency check
      send(0, 35'h14, 0, 0, 0, 3'd0, 1);
      @(negedge clk);
      n_tests++;
      assert (valid_o === 1'b0) else begin
         n_fail++; $error("FAIL latency_c1 obs=%b exp=0", valid_o);
      end
      @(negedge clk);
      n_tests++;
      assert (valid_o === 1'b1 && int_o === 32'd2 && isInexact_o === 1'b1) else begin
         n_fail++; $error("FAIL latency_c2 obs v=%b int=%h exp v=1 int=2", valid_o, int_o);
      end
      step();
      send(0, 35'h1C, 0, 0, 0, 3'd0, 1);           // 3.5 RNE -> 4
      send(1, 35'h2C, 0, 0, 0, 3'd2, 1);           // -5.5 RDN -> -6
      send(1, 35'h2C, 0, 0, 0, 3'd1, 1);           // -5.5 RTZ -> -5
      send(0, {32'h7FFF_FFFF, 3'b100}, 0, 0, 0, 3'd0, 1);  // rounds past max positive
      send(1, {32'h8000_0000, 3'b000}, 0, 0, 0, 3'd0, 1);  // exact min negative
      send(0, 35'h0, 0, 1, 0, 3'd0, 0);            // sNaN unsigned
      send(1, 35'h0, 0, 0, 1, 3'd0, 1);            // qNaN signed, sign ignored
      send(1, 35'h18, 0, 0, 0, 3'd0, 0);           // -3 unsigned -> 0 invalid
      send(1, 35'h2, 0, 0, 0, 3'd1, 0);            // -tiny RTZ unsigned -> 0 not invalid
      send(1, 35'h2, 0, 0, 0, 3'd2, 0);            // -tiny RDN unsigned -> -1 invalid
      send(0, {32'hFFFF_FFFF, 3'b100}, 0, 0, 0, 3'd0, 0);  // carry-out unsigned
      send(0, 35'h14, 0, 0, 0, 3'd4, 1);           // RMM 2.5 -> 3
      send(0, 35'h11, 0, 0, 0, 3'd3, 1);           // RUP sticky only -> 3
      send(1, 35'h0, 1, 0, 0, 3'd0, 1);            // overflow flag, negative signed
      send(0, 35'h14, 0, 0, 0, 3'd7, 1);           // reserved mode acts as RNE
      send(1, 35'h4, 0, 0, 0, 3'd1, 1);            // -0.5 RTZ -> 0
      drain();

      // back-to-back with a 3-cycle downstream stall
      ready_i = 1'b0;
      send(0, 35'h28, 0, 0, 0, 3'd0, 1);
      send(1, 35'h30, 0, 0, 0, 3'd0, 1);
      @(negedge clk);
      n_tests++;
      assert (ready_o === 1'b0 && valid_o === 1'b1) else begin
         n_fail++; $error("FAIL stall_full obs rdy=%b v=%b exp rdy=0 v=1", ready_o, valid_o);
      end
      step();
      step();
      ready_i = 1'b1;
      send(0, 35'h3D, 0, 0, 0, 3'd3, 0);
      send(1, 35'h45, 0, 0, 0, 3'd4, 1);
      drain();

      // reset with two results buffered
      ready_i = 1'b0;
      send(0, 35'h50, 0, 0, 0, 3'd0, 1);
      send(0, 35'h58, 0, 0, 0, 3'd0, 1);
      rst = 1'b0;
      exp_q.delete();
      step();
      @(negedge clk);
      n_tests++;
      assert (valid_o === 1'b0 && int_o === '0) else begin
         n_fail++; $error("FAIL reset_flush obs v=%b int=%h exp v=0 int=0", valid_o, int_o);
      end
      step();
      rst = 1'b1;
      ready_i = 1'b1;
      repeat (4) step();
      @(negedge clk);
      n_tests++;
      assert (valid_o === 1'b0) else begin
         n_fail++; $error("FAIL stale_after_reset obs=%b exp=0", valid_o);
      end
      step();

      // random traffic with random downstream backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rf = {$urandom(), 3'($urandom_range(0, 7))};
         case ($urandom_range(0, 3))
            0: rf[DW+2:3] = 32'($urandom_range(0, 9));
            1: rf[DW+2:3] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            2: rf[DW+2:3] = 32'hFFFF_FFFF;
            default: ;
         endcase
         send(1'($urandom_range(0, 1)), rf, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      rand_rdy = 1'b0;
      ready_i = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
